// File: rtl/msrv32_csr_pkg.sv
// msrv32_csr_pkg: CSR address map and mhpmevent field layout shared by the counter bank
package msrv32_csr_pkg;
  localparam logic [11:0] HPMCOUNTER_BASE  = 12'hB03;
  localparam logic [11:0] HPMCOUNTERH_BASE = 12'hB83;
  localparam logic [11:0] HPMEVENT_BASE    = 12'h323;
  localparam int SEL_W    = 8;
  localparam int SEL_LSB  = 0;
  localparam int SEL_MSB  = SEL_LSB + SEL_W - 1;
  localparam int MINH_BIT = 30;
  localparam int OF_BIT   = 31;
endpackage

// File: rtl/msrv32_hpm_counter.sv
// msrv32_hpm_counter: one performance counter with its event select, inhibit and sticky overflow
module msrv32_hpm_counter
  import msrv32_csr_pkg::*;
#(
  parameter int CNT_WIDTH  = 40,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic                  wr_evt_i,
  input  logic [31:0]           wdata_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic [31:0]           evt_o,
  output logic                  ovf_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 minh_q, minh_d, of_q, of_d;
  logic [255:0]         ev_ext;
  logic                 inc_en, wrap, unused_wdata;
  // bit 0 stays zero so SEL=0 and any SEL beyond NUM_EVENTS select a dead input
  assign ev_ext       = 256'(event_i) << 1;
  assign inc_en       = ev_ext[sel_q] & ~minh_q & ~wr_lo_i;
  assign wrap         = inc_en & ~wr_hi_i & (&cnt_q);
  assign cnt_inc      = inc_en ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  assign unused_wdata = ^wdata_i[MINH_BIT-1:SEL_MSB+1];
  always_comb begin
    cnt_d = cnt_inc;
    if (wr_lo_i) cnt_d[31:0] = wdata_i;
    if (wr_hi_i) cnt_d[CNT_WIDTH-1:32] = (CNT_WIDTH-32)'(wdata_i);
    sel_d  = wr_evt_i ? wdata_i[SEL_MSB:SEL_LSB] : sel_q;
    minh_d = wr_evt_i ? wdata_i[MINH_BIT] : minh_q;
    of_d   = wrap | (wr_evt_i ? wdata_i[OF_BIT] : of_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      minh_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      minh_q <= minh_d;
      of_q   <= of_d;
    end
  end
  assign cnt_o = cnt_q;
  assign evt_o = {of_q, minh_q, 22'b0, sel_q};
  assign ovf_o = of_q;
endmodule

// File: rtl/msrv32_hpm_counter_bank.sv
// msrv32_hpm_counter_bank: bank of mhpmcounter/mhpmevent CSRs with address decode and read mux
module msrv32_hpm_counter_bank
  import msrv32_csr_pkg::*;
#(
  parameter int NUM_CNT    = 4,
  parameter int CNT_WIDTH  = 40,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_en_in,
  input  logic [11:0]           csr_addr_in,
  input  logic [31:0]           data_wr_in,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic [31:0]           csr_data_out,
  output logic                  addr_hit_out,
  output logic [NUM_CNT-1:0]    ovf_vec_out,
  output logic                  ovf_irq_out
);
  logic [NUM_CNT-1:0]   hit_lo, hit_hi, hit_ev;
  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [31:0]          evt [NUM_CNT];
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    assign hit_lo[g] = csr_addr_in == HPMCOUNTER_BASE + 12'(g);
    assign hit_hi[g] = csr_addr_in == HPMCOUNTERH_BASE + 12'(g);
    assign hit_ev[g] = csr_addr_in == HPMEVENT_BASE + 12'(g);
    msrv32_hpm_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_EVENTS(NUM_EVENTS)
    ) u_cnt (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .wr_lo_i (wr_en_in & hit_lo[g]),
      .wr_hi_i (wr_en_in & hit_hi[g]),
      .wr_evt_i(wr_en_in & hit_ev[g]),
      .wdata_i (data_wr_in),
      .event_i (event_in),
      .cnt_o   (cnt[g]),
      .evt_o   (evt[g]),
      .ovf_o   (ovf_vec_out[g])
    );
  end
  always_comb begin
    csr_data_out = '0;
    for (int k = 0; k < NUM_CNT; k++)
      csr_data_out |= ({32{hit_lo[k]}} & cnt[k][31:0])
                    | ({32{hit_hi[k]}} & 32'(cnt[k] >> 32))
                    | ({32{hit_ev[k]}} & evt[k]);
  end
  assign addr_hit_out = |{hit_lo, hit_hi, hit_ev};
  assign ovf_irq_out  = |ovf_vec_out;
endmodule

// File: tb/tb_msrv32_hpm_counter_bank.sv
// tb_msrv32_hpm_counter_bank: directed plus random checks of the counter bank against a CSR-level model
module tb_msrv32_hpm_counter_bank;
  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 8;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          wr_en_in = 1'b0;
  logic [11:0]   csr_addr_in = '0;
  logic [31:0]   data_wr_in = '0;
  logic [NE-1:0] event_in = '0;
  logic [31:0]   csr_data_out;
  logic          addr_hit_out;
  logic [NC-1:0] ovf_vec_out;
  logic          ovf_irq_out;

  msrv32_hpm_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_en_in    (wr_en_in),
    .csr_addr_in (csr_addr_in),
    .data_wr_in  (data_wr_in),
    .event_in    (event_in),
    .csr_data_out(csr_data_out),
    .addr_hit_out(addr_hit_out),
    .ovf_vec_out (ovf_vec_out),
    .ovf_irq_out (ovf_irq_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  logic [CW-1:0] m_cnt [NC];
  logic [7:0]    m_sel [NC];
  logic [NC-1:0] m_minh, m_of;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0;
      m_sel[i] = '0;
    end
    m_minh = '0;
    m_of = '0;
  endtask

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    for (int i = 0; i < NC; i++) begin
      if (a == 12'hB03 + 12'(i)) return m_cnt[i][31:0];
      if (a == 12'hB83 + 12'(i)) return 32'(m_cnt[i] >> 32);
      if (a == 12'h323 + 12'(i)) return {m_of[i], m_minh[i], 22'b0, m_sel[i]};
    end
    return 32'h0;
  endfunction

  function automatic logic m_hit(input logic [11:0] a);
    for (int i = 0; i < NC; i++)
      if (a == 12'hB03 + 12'(i) || a == 12'hB83 + 12'(i) || a == 12'h323 + 12'(i)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the CSR-level rules applied to the inputs currently driven.
  task automatic model_step();
    for (int i = 0; i < NC; i++) begin
      logic [CW-1:0] nc;
      logic hit, wl, wh, we, wrap;
      int s;
      s = int'(m_sel[i]);
      hit = !m_minh[i] && (s >= 1 && s <= NE) ? event_in[s-1] : 1'b0;
      wl = wr_en_in && csr_addr_in == 12'hB03 + 12'(i);
      wh = wr_en_in && csr_addr_in == 12'hB83 + 12'(i);
      we = wr_en_in && csr_addr_in == 12'h323 + 12'(i);
      nc = m_cnt[i];
      wrap = hit && !wl && !wh && nc == {CW{1'b1}};
      if (hit && !wl) nc = nc + 1;
      if (wl) nc[31:0] = data_wr_in;
      if (wh) nc[CW-1:32] = data_wr_in[CW-33:0];
      m_cnt[i] = nc;
      if (we) begin
        m_sel[i] = data_wr_in[7:0];
        m_minh[i] = data_wr_in[30];
        m_of[i] = data_wr_in[31] | wrap;
      end else m_of[i] = m_of[i] | wrap;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    chk("ovf_vec", 64'(ovf_vec_out), 64'(m_of));
    chk("ovf_irq", 64'(ovf_irq_out), 64'(|m_of));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [NE-1:0] ev);
    csr_addr_in = a;
    data_wr_in = d;
    wr_en_in = 1'b1;
    event_in = ev;
    tick();
    wr_en_in = 1'b0;
    event_in = '0;
  endtask

  task automatic idle(input logic [NE-1:0] ev);
    wr_en_in = 1'b0;
    event_in = ev;
    tick();
    event_in = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic h);
    @(negedge clk_in);
    wr_en_in = 1'b0;
    event_in = '0;
    csr_addr_in = a;
    #1;
    d = csr_data_out;
    h = addr_hit_out;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a);
    logic [31:0] d;
    logic h;
    rd(a, d, h);
    chk({tag, "_data"}, 64'(d), 64'(m_rd(a)));
    chk({tag, "_hit"}, 64'(h), 64'(m_hit(a)));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < NC; i++) begin
      rd_chk($sformatf("%s_lo%0d", tag, i), 12'hB03 + 12'(i));
      rd_chk($sformatf("%s_hi%0d", tag, i), 12'hB83 + 12'(i));
      rd_chk($sformatf("%s_ev%0d", tag, i), 12'h323 + 12'(i));
    end
    rd_chk({tag, "_bad_lo"}, 12'hB03 + 12'(NC));
    rd_chk({tag, "_bad_hi"}, 12'hB83 + 12'(NC));
    rd_chk({tag, "_bad_320"}, 12'h320);
    chk({tag, "_ovf_vec"}, 64'(ovf_vec_out), 64'(m_of));
    chk({tag, "_irq"}, 64'(ovf_irq_out), 64'(|m_of));
  endtask

  task automatic rd_exp(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic h;
    rd(a, d, h);
    chk(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    logic [31:0] d;
    logic h;
    m_reset();
    #12;
    sweep("rst0");
    @(negedge clk_in);
    rst_in = 1'b1;

    // counting on event 2 only
    wr(12'h323, 32'h2, '0);
    for (int p = 0; p < 5; p++) begin
      idle(NE'(2));
      idle('0);
      if (p < 3) idle(NE'(1));
    end
    rd_exp("count5", 12'hB03, 32'd5);
    sweep("count");

    // asynchronous reset in the middle of counting
    event_in = '1;
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    m_reset();
    #1;
    chk("rst_irq_now", 64'(ovf_irq_out), 64'h0);
    chk("rst_cnt_now", 64'(dut.g_cnt[0].u_cnt.cnt_o), 64'h0);
    sweep("rst_mid");
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int c = 0; c < 10; c++) idle('1);
    rd_exp("rst_nocount", 12'hB03, 32'd0);
    sweep("rst_post");

    // inhibit takes effect from the cycle after its write
    wr(12'h323, 32'h2, '0);
    wr(12'hB03, 32'h0, NE'(2));
    idle(NE'(2));
    idle(NE'(2));
    wr(12'h323, 32'h4000_0002, NE'(2));
    rd_exp("inh_edge", 12'hB03, 32'd3);
    for (int c = 0; c < 3; c++) idle(NE'(2));
    rd_exp("inh_hold", 12'hB03, 32'd3);
    wr(12'h323, 32'h2, NE'(2));
    rd_exp("inh_wr_edge", 12'hB03, 32'd3);
    idle(NE'(2));
    rd_exp("inh_resume", 12'hB03, 32'd4);

    // wrap at 40 bits and software clear of OF
    wr(12'hB83, 32'hFF, '0);
    wr(12'hB03, 32'hFFFF_FFFE, '0);
    idle(NE'(2));
    idle(NE'(2));
    rd_exp("wrap_lo", 12'hB03, 32'h0);
    rd_exp("wrap_hi", 12'hB83, 32'h0);
    rd_exp("wrap_of", 12'h323, 32'h8000_0002);
    chk("wrap_irq", 64'(ovf_irq_out), 64'h1);
    wr(12'h323, 32'h2, '0);
    chk("of_clr_irq", 64'(ovf_irq_out), 64'h0);

    // write vs increment collisions
    wr(12'hB03, 32'h100, NE'(2));
    rd_exp("coll_cnt", 12'hB03, 32'h100);
    wr(12'hB83, 32'hFF, '0);
    wr(12'hB03, 32'hFFFF_FFFF, '0);
    wr(12'h323, 32'h2, NE'(2));
    rd_exp("coll_of", 12'h323, 32'h8000_0002);
    rd_exp("coll_lo", 12'hB03, 32'h0);

    // unmapped addresses
    rd(12'hB03 + 12'(NC), d, h);
    chk("dec_lo_hit", 64'(h), 64'h0);
    chk("dec_lo_data", 64'(d), 64'h0);
    rd(12'h320, d, h);
    chk("dec_320_hit", 64'(h), 64'h0);
    rd(12'hB83 + 12'(NC), d, h);
    chk("dec_hi_hit", 64'(h), 64'h0);
    wr(12'hB03 + 12'(NC), 32'hDEAD_BEEF, '0);
    wr(12'h320, 32'h8000_0001, '0);
    wr(12'hB83 + 12'(NC), 32'h12, '0);
    wr(12'h323 + 12'(NC), 32'h8000_0001, '0);
    sweep("dec");

    // randomized traffic
    for (int i = 0; i < NC; i++) wr(12'h323 + 12'(i), 32'($urandom_range(10)), '0);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) begin
        int k, t, r;
        logic [11:0] a;
        logic [31:0] v;
        k = $urandom_range(NC);
        t = $urandom_range(3);
        r = $urandom_range(3);
        a = t == 0 ? 12'hB03 + 12'(k) : t == 1 ? 12'hB83 + 12'(k) :
            t == 2 ? 12'h323 + 12'(k) : 12'h320;
        v = r == 0 ? 32'hFFFF_FFFF : r == 1 ? 32'hFFFF_FFF0 : $urandom;
        if (t >= 2) v = $urandom & 32'hC000_000F;
        wr(a, v, NE'($urandom));
      end else idle(NE'($urandom));
      if (c % 150 == 149) sweep($sformatf("rnd%0d", c));
    end
    sweep("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/msrv32_hpm_counter_bank.md
# msrv32_hpm_counter_bank

Parametrised bank of machine hardware performance-monitor counters (mhpmcounter3.., mhpmcounterh3.., mhpmevent3..) for the msrv32 CSR file. Each counter counts one selectable event per cycle and has a per-counter inhibit. On wrap it sets a sticky overflow flag and raises a local overflow interrupt request. The block sits beside the existing machine counter logic. It takes the already-resolved CSR write data and returns read data plus an address-hit flag to the CSR read mux.

## Interface
Parameters:
- NUM_CNT, 4: number of counters, 1..29; counter i maps to CSR index 3+i.
- CNT_WIDTH, 40: implemented counter width, 33..64.
- NUM_EVENTS, 8: width of the event input vector, 1..255.

Ports:
- clk_in  input  1  core clock.
- rst_in  input  1  reset; one clock; reset is asynchronous and active-low.
- wr_en_in  input  1  CSR write strobe; qualified by csr_addr_in.
- csr_addr_in  input  12  CSR address.
- data_wr_in  input  32  final CSR write value, after RW/RS/RC resolution.
- event_in  input  NUM_EVENTS  per-cycle event pulses; bit k is event k+1.
- csr_data_out  output  32  read data for csr_addr_in; 0 when not hit.
- addr_hit_out  output  1  csr_addr_in maps to a register in this block.
- ovf_vec_out  output  NUM_CNT  per-counter sticky overflow flags (OF).
- ovf_irq_out  output  1  OR of ovf_vec_out.

## Operation
Address map, i in 0..NUM_CNT-1:
- 0xB03+i: counter[31:0].
- 0xB83+i: counter[CNT_WIDTH-1:32]; unimplemented upper bits read 0 and ignore writes.
- 0x323+i: mhpmevent. Fields: [7:0] SEL, [30] MINH, [31] OF. Other bits read 0 and ignore writes.

Counting:
- Counter i increments by 1 when MINH=0, SEL is in 1..NUM_EVENTS, and event_in[SEL-1]=1.
- SEL=0 or SEL>NUM_EVENTS never counts.
- Counting uses the registered SEL/MINH values, so a new configuration takes effect from the cycle after its write.
- Wrap: all-ones at CNT_WIDTH bits goes to 0 and sets OF in the same edge.

CSR writes:
- A low-half write replaces bits [31:0] and keeps the high bits. A high-half write replaces the high bits and keeps the low half.
- A write to a counter half in the same cycle as an increment: the write wins and the increment is lost. A carry from the low half into the high half is also lost when the high half is written.
- An mhpmevent write loads SEL, MINH and OF from data_wr_in. If the counter wraps in the same cycle, OF=1 regardless of data_wr_in[31] (hardware set wins).
- OF is cleared only by software writing 0.
- Writes to unmapped addresses, or to indices ≥NUM_CNT, are ignored; addr_hit_out=0 for them.

Reset values: all counters 0, SEL=0, MINH=0, OF=0. Hence csr_data_out=0, ovf_vec_out=0, ovf_irq_out=0.

## Timing
- Reads are combinational from csr_addr_in and current state, zero latency, matching the existing CSR read mux.
- A write on edge N is visible on csr_data_out after edge N.
- Increment latency: an event sampled at edge N is counted in the value seen after edge N.
- OF and ovf_irq_out rise after the wrapping edge. No extra register stage: ovf_irq_out is the combinational OR of the OF registers.
- Asynchronous reset assertion mid-count clears all state immediately. Counting resumes at the first edge after deassertion, with reset configuration, so nothing counts until SEL is written.
- Multiple counters may increment and wrap in the same cycle; each behaves independently.

## Structure
- Shared package msrv32_csr_pkg holds:
  - address constants: HPMCOUNTER_BASE=12'hB03, HPMCOUNTERH_BASE=12'hB83, HPMEVENT_BASE=12'h323;
  - mhpmevent field positions: SEL_LSB/MSB, MINH_BIT, OF_BIT;
  - event-select width 8.
- One sub-module, msrv32_hpm_counter: a single counter plus its event register, write-priority logic and OF logic.
- The top level instantiates NUM_CNT copies with a generate loop and performs address decode and read muxing.

## Test plan
- Reset: hold rst_in low mid-count -> every CSR reads 0, ovf_irq_out=0; after release with event_in all-ones for 10 cycles, counters stay 0.
- Counting: write 0x323 <- 0x00000002, pulse event_in[1] on 5 non-consecutive cycles plus event_in[0] on 3 others -> 0xB03 reads 5.
- Inhibit/config timing: write 0x323 <- 0x40000002 while event_in[1] held high -> count stops exactly after the write edge; rewrite 0x00000002 -> counting resumes the next cycle.
- Wrap/overflow (CNT_WIDTH=40): write 0xB83 <- 0xFF, 0xB03 <- 0xFFFFFFFE, count 2 events -> 0xB03=0, 0xB83=0, 0x323 bit31=1, ovf_irq_out=1; write 0x323 <- 0x2 -> ovf_irq_out=0.
- Collision: write 0xB03 <- 0x100 in the same cycle as an event -> reads 0x100. mhpmevent write with bit31=0 on the wrapping cycle -> OF=1.
- Decode: read 0xB03+NUM_CNT, 0x320 and 0xB83+NUM_CNT -> addr_hit_out=0, csr_data_out=0; writes to them leave all state unchanged.
